// File: rtl/scanline_pkg.sv
// Shared widths, types and the 2C02 master palette for the scanline colour buffer.
// Palette entries are packed {B,G,R}, each channel the upper nibble of the 8-bit value.
package scanline_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned RGB_W  = 12;

  typedef logic [IDX_W-1:0] color_idx_t;
  typedef logic [RGB_W-1:0] rgb12_t;

  localparam rgb12_t NES_PALETTE [0:63] = '{
    12'h777, 12'hF00, 12'hB00, 12'hB24, 12'h809, 12'h20A, 12'h01A, 12'h018,
    12'h035, 12'h070, 12'h060, 12'h050, 12'h540, 12'h000, 12'h000, 12'h000,
    12'hBBB, 12'hF70, 12'hF50, 12'hF46, 12'hC0D, 12'h50E, 12'h03F, 12'h15E,
    12'h07A, 12'h0B0, 12'h0A0, 12'h4A0, 12'h880, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'hFB3, 12'hF86, 12'hF79, 12'hF7F, 12'h95F, 12'h57F, 12'h4AF,
    12'h0BF, 12'h1FB, 12'h5D5, 12'h9F5, 12'hDE0, 12'h777, 12'h000, 12'h000,
    12'hFFF, 12'hFEA, 12'hFBB, 12'hFBD, 12'hFBF, 12'hCAF, 12'hBDF, 12'hAEF,
    12'h7DF, 12'h7FD, 12'hBFB, 12'hDFB, 12'hFF0, 12'hFDF, 12'h000, 12'h000
  };

endpackage

// File: rtl/scanline_dpram.sv
// Generic read-first true dual-port RAM, single clock, per-port enable and write strobe.
// Array contents are never reset; only the read registers are.
module scanline_dpram #(
  parameter int unsigned AddrW = 9,
  parameter int unsigned DataW = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_en_i,
  input  logic             a_we_i,
  input  logic [AddrW-1:0] a_addr_i,
  input  logic [DataW-1:0] a_wdata_i,
  output logic [DataW-1:0] a_rdata_o,
  input  logic             b_en_i,
  input  logic             b_we_i,
  input  logic [AddrW-1:0] b_addr_i,
  input  logic [DataW-1:0] b_wdata_i,
  output logic [DataW-1:0] b_rdata_o
);

  logic [DataW-1:0] mem_q [2**AddrW];
  logic [DataW-1:0] a_rdata_q, b_rdata_q;

  // Port B is listed last, so it wins a same-address double write.
  always_ff @(posedge clk) begin
    if (a_en_i && a_we_i) mem_q[a_addr_i] <= a_wdata_i;
    if (b_en_i && b_we_i) mem_q[b_addr_i] <= b_wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_en_i) a_rdata_q <= mem_q[a_addr_i];
      if (b_en_i) b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/scanline_color_buf.sv
// Double-line scan buffer with NES palette lookup: PPU writes indices, VGA reads RGB.
// Optional SCANLINE_GRAYSCALE_EN masks the lookup index to its luma column on request.
module scanline_color_buf
  import scanline_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic              vga_en,
  output logic [RGB_W-1:0]  rgb,
  output logic              rgb_valid,
  input  logic [ADDR_W-1:0] ppu_addr,
  input  logic              ppu_en,
  input  logic              ppu_we,
  input  logic [IDX_W-1:0]  ppu_wdata,
  output logic [IDX_W-1:0]  ppu_rdata,
  input  logic              grayscale
);

  color_idx_t idx_q;
  color_idx_t lut_idx;
  logic       v1_q;
  logic       rgb_valid_q;
  rgb12_t     rgb_q;

  scanline_dpram #(
    .AddrW (ADDR_W),
    .DataW (IDX_W)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .a_en_i    (ppu_en),
    .a_we_i    (ppu_we),
    .a_addr_i  (ppu_addr),
    .a_wdata_i (ppu_wdata),
    .a_rdata_o (ppu_rdata),
    .b_en_i    (vga_en),
    .b_we_i    (1'b0),
    .b_addr_i  (vga_addr),
    .b_wdata_i ('0),
    .b_rdata_o (idx_q)
  );

`ifdef SCANLINE_GRAYSCALE_EN
  always_comb begin
    lut_idx = idx_q;
    if (grayscale) lut_idx = {idx_q[5:4], 4'h0};
  end
`else
  logic unused_grayscale;
  assign unused_grayscale = grayscale;

  always_comb begin
    lut_idx = idx_q;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q        <= 1'b0;
      rgb_valid_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      v1_q        <= vga_en;
      rgb_valid_q <= v1_q;
      if (v1_q) rgb_q <= NES_PALETTE[lut_idx];
    end
  end

  assign rgb       = rgb_q;
  assign rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_scanline_color_buf.sv
// Directed self-checking bench for scanline_color_buf (default or SCANLINE_GRAYSCALE_EN build).
module tb_scanline_color_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  vga_addr;
  logic        vga_en;
  logic [11:0] rgb;
  logic        rgb_valid;
  logic [8:0]  ppu_addr;
  logic        ppu_en;
  logic        ppu_we;
  logic [5:0]  ppu_wdata;
  logic [5:0]  ppu_rdata;
  logic        grayscale;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  scanline_color_buf dut (
    .clk       (clk),
    .reset     (reset),
    .vga_addr  (vga_addr),
    .vga_en    (vga_en),
    .rgb       (rgb),
    .rgb_valid (rgb_valid),
    .ppu_addr  (ppu_addr),
    .ppu_en    (ppu_en),
    .ppu_we    (ppu_we),
    .ppu_wdata (ppu_wdata),
    .ppu_rdata (ppu_rdata),
    .grayscale (grayscale)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ppu_write(input logic [8:0] addr, input logic [5:0] data);
    ppu_en = 1'b1; ppu_we = 1'b1; ppu_addr = addr; ppu_wdata = data;
    tick();
    ppu_en = 1'b0; ppu_we = 1'b0;
  endtask

  // Single VGA read; returns after the second edge, when rgb should be valid.
  task automatic vga_read(input logic [8:0] addr);
    vga_en = 1'b1; vga_addr = addr;
    tick();
    vga_en = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; vga_addr = '0; vga_en = 1'b0; ppu_addr = '0; ppu_en = 1'b0;
    ppu_we = 1'b0; ppu_wdata = '0; grayscale = 1'b0;
    tick(); tick();
    check_eq("reset_rgb", 16'(rgb), 16'h000);
    check_eq("reset_valid", 16'(rgb_valid), 16'h0);
    check_eq("reset_ppu_rdata", 16'(ppu_rdata), 16'h00);
    reset = 1'b0;
    tick();

    // Write then display with two-cycle latency
    ppu_write(9'h105, 6'h30);
    vga_en = 1'b1; vga_addr = 9'h105;
    tick();
    vga_en = 1'b0;
    check_eq("wd_stage1_not_valid", 16'(rgb_valid), 16'h0);
    tick();
    check_eq("wd_rgb", 16'(rgb), 16'hFFF);
    check_eq("wd_valid", 16'(rgb_valid), 16'h1);
    tick();
    check_eq("wd_valid_drop", 16'(rgb_valid), 16'h0);
    check_eq("wd_rgb_hold", 16'(rgb), 16'hFFF);

    // Read-first PPU readback
    ppu_write(9'h020, 6'h0F);
    ppu_en = 1'b1; ppu_we = 1'b1; ppu_addr = 9'h020; ppu_wdata = 6'h16;
    tick();
    check_eq("rf_old", 16'(ppu_rdata), 16'h0F);
    ppu_we = 1'b0;
    tick();
    check_eq("rf_new", 16'(ppu_rdata), 16'h16);
    ppu_en = 1'b0; ppu_addr = 9'h105;
    tick();
    check_eq("rf_hold", 16'(ppu_rdata), 16'h16);

    // Line isolation, back-to-back reads
    ppu_write(9'h0FF, 6'h20);
    ppu_write(9'h1FF, 6'h0F);
    vga_en = 1'b1; vga_addr = 9'h0FF;
    tick();
    vga_addr = 9'h1FF;
    tick();
    vga_en = 1'b0;
    check_eq("line0_rgb", 16'(rgb), 16'hFFF);
    check_eq("line0_valid", 16'(rgb_valid), 16'h1);
    tick();
    check_eq("line1_rgb", 16'(rgb), 16'h000);
    check_eq("line1_valid", 16'(rgb_valid), 16'h1);

    // Same-cycle write/read collision returns old data
    ppu_write(9'h040, 6'h0F);
    ppu_en = 1'b1; ppu_we = 1'b1; ppu_addr = 9'h040; ppu_wdata = 6'h30;
    vga_en = 1'b1; vga_addr = 9'h040;
    tick();
    ppu_en = 1'b0; ppu_we = 1'b0; vga_en = 1'b0;
    tick();
    check_eq("coll_old", 16'(rgb), 16'h000);
    vga_read(9'h040);
    check_eq("coll_reread", 16'(rgb), 16'hFFF);

    // Reset mid-stream
    vga_en = 1'b1; vga_addr = 9'h105;
    tick(); tick(); tick();
    check_eq("stream_valid", 16'(rgb_valid), 16'h1);
    reset = 1'b1;
    #1;
    check_eq("rst_async_rgb", 16'(rgb), 16'h000);
    check_eq("rst_async_valid", 16'(rgb_valid), 16'h0);
    check_eq("rst_async_ppu", 16'(ppu_rdata), 16'h00);
    tick();
    reset = 1'b0; vga_en = 1'b0;
    tick();
    check_eq("rst_no_inflight", 16'(rgb_valid), 16'h0);
    vga_en = 1'b1; vga_addr = 9'h105;
    tick();
    vga_en = 1'b0;
    check_eq("rst_first_stage1", 16'(rgb_valid), 16'h0);
    tick();
    check_eq("rst_reread_valid", 16'(rgb_valid), 16'h1);
    check_eq("rst_reread_rgb", 16'(rgb), 16'hFFF);

    // Grayscale masking (ignored in the default build)
    ppu_write(9'h0A0, 6'h36);
    grayscale = 1'b1;
    vga_read(9'h0A0);
`ifdef SCANLINE_GRAYSCALE_EN
    check_eq("gray_on", 16'(rgb), 16'hFFF);
`else
    check_eq("gray_ignored", 16'(rgb), 16'hBDF);
`endif
    grayscale = 1'b0;
    vga_read(9'h0A0);
    check_eq("gray_off", 16'(rgb), 16'hBDF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/scanline_color_buf.md
Name: scanline_color_buf

Overview:
- Double-line scan buffer between the PPU pixel pipeline and the VGA output stage, merged with the NES master-palette lookup.
- The PPU writes 6-bit colour indices into one line half and can read back the index at the same address for priority/cover checks.
- The VGA side reads the other half by {line parity, x} and receives 12-bit RGB two cycles later.
- Single clock domain (the 100 MHz memory clock).

Parameters:
- ADDR_W, 9, buffer address width; 2 lines x 256 pixels; bit 8 selects the line.
- IDX_W, 6, colour-index width; 64 palette entries.
- RGB_W, 12, output colour width, 4 bits per channel.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- vga_addr  input  9  VGA read address: bit 8 = line parity (v_c[0]), bits 7:0 = x.
- vga_en  input  1  VGA read enable.
- rgb  output  12  {B[3:0],G[3:0],R[3:0]}.
- rgb_valid  output  1  rgb holds data for a vga_en issued two cycles earlier.
- ppu_addr  input  9  PPU-side address.
- ppu_en  input  1  PPU-side port enable.
- ppu_we  input  1  PPU write strobe; honoured only when ppu_en=1.
- ppu_wdata  input  6  colour index to write.
- ppu_rdata  output  6  index stored at ppu_addr before this cycle's write (read-first).
- grayscale  input  1  grayscale request; see Optional Feature.

Behaviour:
- Storage: 512 x 6 true dual-port RAM. Contents are not cleared by reset, and every index must be written before it is displayed.
- PPU port, 1-cycle latency:
  - When ppu_en=1, ppu_rdata <= mem[ppu_addr].
  - If ppu_we=1 in the same cycle, mem[ppu_addr] <= ppu_wdata.
  - Read-first: ppu_rdata returns the old value.
  - When ppu_en=0, ppu_rdata holds its previous value.
- VGA port, 2-cycle pipeline:
  - Stage 1: when vga_en=1, idx_q <= mem[vga_addr].
  - Stage 2: rgb <= NES_PALETTE[idx_q].
  - Both stages advance only while their valid bit flows: v1 <= vga_en, rgb_valid <= v1.
  - When a stage is not valid, its data register holds its previous value.
  - Back-to-back reads sustain one pixel per cycle.
- Write/read collision at the same address in the same cycle: the VGA port returns the old data. There is no forwarding.
- Addresses are full 9-bit. 0x0FF and 0x100 are different lines, so the buffer never wraps across lines.
- Palette:
  - 64-entry constant ROM holding the 2C02 master palette; each channel is the upper nibble of the 8-bit standard value.
  - Required entries: 0x0D/0x0E/0x0F/0x1D/0x1E/0x1F/0x2E/0x2F/0x3E/0x3F = 0x000, 0x20 = 0xFFF, 0x30 = 0xFFF.
- Reset (async assert, sync deassert handled upstream):
  - rgb=0, rgb_valid=0, v1=0, idx_q=0, ppu_rdata=0.
  - Reset asserted mid-pipeline drops all in-flight reads. The first rgb_valid appears two cycles after the first post-reset vga_en.

Optional Feature:
- Macro: SCANLINE_GRAYSCALE_EN.
- Defined: when grayscale=1, stage 2 uses the index {idx_q[5:4],4'h0}, matching PPUMASK bit0. grayscale is sampled in stage 2, in the same cycle as the lookup.
- Undefined: the grayscale port is present but ignored, and the lookup uses idx_q unchanged.

Decomposition:
- Package scanline_pkg holds:
  - ADDR_W, IDX_W, RGB_W localparams.
  - typedefs color_idx_t (6b) and rgb12_t (12b).
  - NES_PALETTE constant array [0:63] of rgb12_t.
- One sub-module, scanline_dpram: generic read-first true dual-port RAM, 512x6, one clock, per-port enable/write.
- Palette lookup and pipeline registers live in the top module.

Test Plan:
- Write-then-display: PPU writes 0x30 at 0x105, then the bench issues vga_en with vga_addr=0x105 → two cycles later rgb=0xFFF and rgb_valid=1.
- Read-first readback: write 0x0F at 0x020 in one cycle. Next cycle write 0x16 at 0x020 with ppu_en=1 → ppu_rdata=0x0F. The cycle after, ppu_en=1 with ppu_we=0 → ppu_rdata=0x16.
- Line isolation: write 0x20 at 0x0FF and 0x0F at 0x1FF. VGA reads 0x0FF then 0x1FF back-to-back → rgb = 0xFFF then 0x000 on consecutive cycles.
- Collision: mem[0x040]=0x0F. Same cycle: PPU writes 0x30 to 0x040 and VGA reads 0x040 → rgb=0x000. A re-read of 0x040 → 0xFFF.
- Reset mid-stream: stream vga_en reads, then assert reset for one cycle → rgb=0x000 and rgb_valid=0 immediately. RAM still holds the data: a re-read after reset returns the pre-reset colour.
- With SCANLINE_GRAYSCALE_EN: mem holds 0x36, grayscale=1 → rgb equals NES_PALETTE[0x30]=0xFFF. With grayscale=0 → rgb equals NES_PALETTE[0x36].
